// File: rtl/lsu_if.sv
// lsu_if: bundles the core request/response handshake and the data memory port of the
// load/store unit.
//   slave  modport: the LSU side (takes requests, drives responses and the memory port)
//   master modport: the core/memory side (drives requests, consumes responses, returns data)
// Signals: req_valid/req_ready/req_write/req_size/req_signed/req_address/req_wdata,
//          resp_valid/resp_ready/resp_rdata/resp_fault,
//          memory_address/memory_in/memory_size/memory_write_enable/memory_out.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] memory_address;
    logic [31:0] memory_in;
    logic [1:0]  memory_size;
    logic        memory_write_enable;
    logic [31:0] memory_out;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_address, req_wdata,
        input  resp_ready, memory_out,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output memory_address, memory_in, memory_size, memory_write_enable
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_address, req_wdata,
        output resp_ready, memory_out,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  memory_address, memory_in, memory_size, memory_write_enable
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the byte-lane data memory port. Accepts one load/store
// at a time, drives registered memory_* outputs, waits READ_LATENCY cycles for load data,
// extends it to 32 bits and returns it on a valid/ready response channel.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - lsu_if.slave: request, response and memory port signals
// Parameter:
//   READ_LATENCY - cycles from address presented to memory_out valid (1..7)
// Optional feature: define LSU_ALIGN_CHECK_EN to fault misaligned accesses and size 11
// without touching memory; otherwise resp_fault is always 0 and all accesses go to memory.
module load_store_unit #(
    parameter int unsigned READ_LATENCY = 1
) (
    input logic  clk,
    input logic  rst,
    lsu_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

    localparam logic [2:0] CntInit = 3'(READ_LATENCY - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic        we_q, we_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic        misaligned;
    logic [31:0] load_ext;

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = (bus.req_size == 2'b01 && bus.req_address[0]) ||
                        (bus.req_size == 2'b10 && bus.req_address[1:0] != 2'b00) ||
                        (bus.req_size == 2'b11);
`else
    assign misaligned = 1'b0;
`endif

    // Memory returns data low-justified; size 11 is treated as word.
    always_comb begin
        unique case (size_q)
            2'b00:   load_ext = {{24{signed_q & bus.memory_out[7]}}, bus.memory_out[7:0]};
            2'b01:   load_ext = {{16{signed_q & bus.memory_out[15]}}, bus.memory_out[15:0]};
            default: load_ext = bus.memory_out;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        signed_d = signed_q;
        we_d     = 1'b0;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (misaligned) begin
                        // No memory access: memory_* registers keep their old values.
                        fault_d = 1'b1;
                        rdata_d = 32'h0;
                        state_d = StResp;
                    end else begin
                        addr_d   = bus.req_address;
                        wdata_d  = bus.req_wdata;
                        size_d   = bus.req_size;
                        signed_d = bus.req_signed;
                        fault_d  = 1'b0;
                        if (bus.req_write) begin
                            we_d    = 1'b1;
                            state_d = StWrite;
                        end else begin
                            cnt_d   = CntInit;
                            state_d = StRead;
                        end
                    end
                end
            end
            StWrite: begin
                rdata_d = 32'h0;
                state_d = StResp;
            end
            StRead: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = load_ext;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            we_q     <= 1'b0;
            cnt_q    <= 3'd0;
            rdata_q  <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.req_ready           = (state_q == StIdle);
    assign bus.resp_valid          = (state_q == StResp);
    assign bus.resp_rdata          = rdata_q;
    assign bus.resp_fault          = fault_q;
    assign bus.memory_address      = addr_q;
    assign bus.memory_in           = wdata_q;
    assign bus.memory_size         = size_q;
    assign bus.memory_write_enable = we_q;

endmodule
